pgr_fft_stage_sched: RTL and testbench

// - Sequences the burst radix-2 FFT/IFFT butterfly datapath: walks LOG2_N stages, issuing N/2 pair reads per stage.
// - Drives the read-side inputs of the output switch: rd_addr, rd_valid and first_level.
// - Inserts a fixed drain gap between stages so stage s writeback completes before stage s+1 reads.
// - Reports busy/done to the FFT top-level control.

---
 rtl/pgr_fft_stage_sched.sv | 164 ++++++++++++++++
 tb/tb_pgr_fft_stage_sched.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pgr_fft_stage_sched.sv
// Stage/pair read scheduler for the burst radix-2 FFT/IFFT butterfly datapath.
// Optional build macro PGR_FFT_SCHED_BITREV_EN: bit-reversed pair addressing in stage 0.
module pgr_fft_stage_sched #(
  parameter int LOG2_N       = 10,
  parameter int ADDR_WIDTH   = 18,
  parameter int DRAIN_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  rd_ready,
  output logic                  busy,
  output logic                  done,
  output logic [4:0]            stage,
  output logic                  first_level,
  output logic                  rd_valid,
  output logic [ADDR_WIDTH-1:0] rd_addr
);

  localparam int KW = LOG2_N - 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [KW-1:0] K_LAST     = {KW{1'b1}};
  localparam logic [4:0]    STAGE_LAST = 5'(LOG2_N - 1);
  localparam logic [7:0]    DRAIN_LOAD = 8'(DRAIN_CYCLES);

  logic [1:0]            state_r;
  logic [KW-1:0]         k_r;
  logic [7:0]            drain_r;
  logic [4:0]            stage_r;
  logic                  busy_r;
  logic                  done_r;
  logic                  first_level_r;
  logic                  rd_valid_r;
  logic [ADDR_WIDTH-1:0] rd_addr_r;
  logic [KW-1:0]         addr_map_s;

`ifdef PGR_FFT_SCHED_BITREV_EN
  function automatic logic [KW-1:0] bitrev(input logic [KW-1:0] v);
    logic [KW-1:0] r;
    for (int i = 0; i < KW; i++) begin
      r[i] = v[KW-1-i];
    end
    return r;
  endfunction

  // Stage 0 reads natural-order input, so its pair index is bit-reversed.
  always_comb begin
    addr_map_s = k_r;
    if (stage_r == 5'd0) begin
      addr_map_s = bitrev(k_r);
    end else begin
      addr_map_s = k_r;
    end
  end
`else
  // Input arrives pre-ordered; pair index maps straight to the address.
  always_comb begin
    addr_map_s = k_r;
  end
`endif

  // Scheduler FSM with all outputs registered; abort acts as a synchronous return to idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      k_r           <= {KW{1'b0}};
      drain_r       <= 8'd0;
      stage_r       <= 5'd0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      first_level_r <= 1'b0;
      rd_valid_r    <= 1'b0;
      rd_addr_r     <= {ADDR_WIDTH{1'b0}};
    end else if (abort) begin
      state_r       <= ST_IDLE;
      k_r           <= {KW{1'b0}};
      drain_r       <= 8'd0;
      stage_r       <= 5'd0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      first_level_r <= 1'b0;
      rd_valid_r    <= 1'b0;
      rd_addr_r     <= {ADDR_WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r     <= 1'b0;
          rd_valid_r <= 1'b0;
          if (start) begin
            state_r       <= ST_RUN;
            busy_r        <= 1'b1;
            stage_r       <= 5'd0;
            first_level_r <= 1'b1;
            k_r           <= {KW{1'b0}};
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          // A stalled cycle holds k and rd_addr so no pair is skipped or repeated.
          if (rd_ready) begin
            rd_valid_r <= 1'b1;
            rd_addr_r  <= ADDR_WIDTH'(addr_map_s);
            if (k_r == K_LAST) begin
              state_r <= ST_DRAIN;
              drain_r <= DRAIN_LOAD;
            end else begin
              k_r <= k_r + {{(KW-1){1'b0}}, 1'b1};
            end
          end else begin
            rd_valid_r <= 1'b0;
          end
        end
        ST_DRAIN: begin
          rd_valid_r <= 1'b0;
          if (drain_r == 8'd1) begin
            k_r           <= {KW{1'b0}};
            drain_r       <= 8'd0;
            first_level_r <= 1'b0;
            if (stage_r == STAGE_LAST) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
              busy_r  <= 1'b0;
              stage_r <= 5'd0;
            end else begin
              state_r <= ST_RUN;
              stage_r <= stage_r + 5'd1;
            end
          end else begin
            drain_r <= drain_r - 8'd1;
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          state_r       <= ST_IDLE;
          k_r           <= {KW{1'b0}};
          drain_r       <= 8'd0;
          stage_r       <= 5'd0;
          busy_r        <= 1'b0;
          done_r        <= 1'b0;
          first_level_r <= 1'b0;
          rd_valid_r    <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign stage       = stage_r;
  assign first_level = first_level_r;
  assign rd_valid    = rd_valid_r;
  assign rd_addr     = rd_addr_r;

endmodule

// File: tb/tb_pgr_fft_stage_sched.sv
// Directed bench for pgr_fft_stage_sched at LOG2_N=4, DRAIN_CYCLES=6.
module tb_pgr_fft_stage_sched;

  localparam int AW = 18;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          rd_ready = 1'b0;
  logic          busy;
  logic          done;
  logic [4:0]    stage;
  logic          first_level;
  logic          rd_valid;
  logic [AW-1:0] rd_addr;

  int checks = 0;
  int errors = 0;
  int busy_cnt = 0;
  int br_tab[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  pgr_fft_stage_sched #(.LOG2_N(4), .ADDR_WIDTH(AW), .DRAIN_CYCLES(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .rd_ready(rd_ready),
    .busy(busy), .done(done), .stage(stage), .first_level(first_level),
    .rd_valid(rd_valid), .rd_addr(rd_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic st; logic ab; logic rdy;
    logic e_busy; logic e_done; int e_stage; logic e_first; logic e_valid; int e_addr;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (busy) busy_cnt++;
  endtask

  function automatic int exp_addr(input int s, input int i);
`ifdef PGR_FFT_SCHED_BITREV_EN
    if (s == 0) return br_tab[i];
`endif
    return i;
  endfunction

  task automatic check_idle(input string name);
    check({name, "_busy"}, int'(busy), 0);
    check({name, "_done"}, int'(done), 0);
    check({name, "_valid"}, int'(rd_valid), 0);
    check({name, "_stage"}, int'(stage), 0);
    check({name, "_first"}, int'(first_level), 0);
  endtask

  // Full transform from a start pulse; optional rd_ready toggling in stage 1,
  // optional start re-pulse and abort in stage abort_stage.
  task automatic run_transform(input int toggle_s1, input int abort_stage);
    busy_cnt = 0;
    rd_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    check("accept_busy", int'(busy), 1);
    check("accept_valid", int'(rd_valid), 0);
    check("accept_first", int'(first_level), 1);
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < 8; i++) begin
        if (toggle_s1 != 0 && s == 1 && i > 0) begin
          rd_ready = 1'b0;
          step();
          check("stall_valid", int'(rd_valid), 0);
          check("stall_addr", int'(rd_addr), exp_addr(s, i - 1));
          rd_ready = 1'b1;
        end
        if (s == abort_stage && i == 3) start = 1'b1;
        step();
        start = 1'b0;
        check("run_valid", int'(rd_valid), 1);
        check("run_addr", int'(rd_addr), exp_addr(s, i));
        check("run_stage", int'(stage), s);
        check("run_first", int'(first_level), (s == 0) ? 1 : 0);
        check("run_busy", int'(busy), 1);
        check("run_done", int'(done), 0);
      end
      for (int d = 0; d < 6; d++) begin
        if (s == abort_stage && d == 2) begin
          abort = 1'b1;
          step();
          abort = 1'b0;
          check_idle("abort");
          for (int j = 0; j < 10; j++) begin
            step();
            check("post_abort_done", int'(done), 0);
            check("post_abort_busy", int'(busy), 0);
          end
          return;
        end
        step();
        check("drain_valid", int'(rd_valid), 0);
        if (d < 5) begin
          check("drain_stage", int'(stage), s);
          check("drain_first", int'(first_level), (s == 0) ? 1 : 0);
          check("drain_busy", int'(busy), 1);
          check("drain_done", int'(done), 0);
        end else if (s < 3) begin
          check("next_stage", int'(stage), s + 1);
          check("next_first", int'(first_level), 0);
          check("next_busy", int'(busy), 1);
          check("next_done", int'(done), 0);
        end else begin
          check("done_pulse", int'(done), 1);
          check("done_busy", int'(busy), 0);
          check("done_stage", int'(stage), 0);
        end
      end
    end
    start = 1'b1;
    step();
    start = 1'b0;
    check_idle("after_done");
    step();
    check_idle("after_done2");
    if (toggle_s1 == 0) check("busy_cycles", busy_cnt, 4 * 8 + 4 * 6);
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 0};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0, 0};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b1, 0};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b1, exp_addr(0, 1)};
    vecs[7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b1, exp_addr(0, 2)};
    vecs[8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0};
    vecs[9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0};

    #12;
    check_idle("reset");
    check("reset_addr", int'(rd_addr), 0);
    rst_n = 1'b1;

    for (int v = 0; v < 10; v++) begin
      start = vecs[v].st;
      abort = vecs[v].ab;
      rd_ready = vecs[v].rdy;
      step();
      check($sformatf("vec%0d_busy", v), int'(busy), int'(vecs[v].e_busy));
      check($sformatf("vec%0d_done", v), int'(done), int'(vecs[v].e_done));
      check($sformatf("vec%0d_stage", v), int'(stage), vecs[v].e_stage);
      check($sformatf("vec%0d_first", v), int'(first_level), int'(vecs[v].e_first));
      check($sformatf("vec%0d_valid", v), int'(rd_valid), int'(vecs[v].e_valid));
      if (vecs[v].e_valid) check($sformatf("vec%0d_addr", v), int'(rd_addr), vecs[v].e_addr);
    end
    start = 1'b0;
    abort = 1'b0;

    run_transform(0, -1);
    run_transform(1, -1);
    run_transform(0, 2);
    run_transform(0, -1);

    // Async reset in the middle of stage 1 RUN.
    rd_ready = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 17; i++) step();
    check("pre_rst_stage", int'(stage), 1);
    check("pre_rst_valid", int'(rd_valid), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("async_rst");
    check("async_rst_addr", int'(rd_addr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("post_rst_busy", int'(busy), 0);
      check("post_rst_valid", int'(rd_valid), 0);
    end
    run_transform(0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
